traffic_light_monitor: RTL and testbench

Receive-side checker for the 3-bit {Red, Yellow, Green} lights bus driven by the traffic light controller. It decodes each sampled lights value into a phase and checks that phases follow the legal order RED -> GREEN -> YELLOW -> RED. It also checks each phase dwell time against the configured length, raises a sticky fault with a code, and counts fully verified cycles. It sits beside the controller in the top level and in the bench as a protocol checker / health monitor.

---
 rtl/tlc_pkg.sv | 57 +++++
 rtl/tlc_phase_decode.sv | 21 ++
 rtl/traffic_light_monitor.sv | 128 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared lights encodings, phase/fault codes and monitor state type
package tlc_pkg;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        FLT_NONE  = 3'd0,
        FLT_ENC   = 3'd1,
        FLT_TRANS = 3'd2,
        FLT_SHORT = 3'd3,
        FLT_LONG  = 3'd4
    } fault_t;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } state_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_NONE;
        endcase
    endfunction

    function automatic phase_t state_phase(input state_t s);
        case (s)
            ST_RED:    return PH_RED;
            ST_GREEN:  return PH_GREEN;
            ST_YELLOW: return PH_YELLOW;
            default:   return PH_NONE;
        endcase
    endfunction

    function automatic state_t phase_state(input phase_t p);
        case (p)
            PH_RED:    return ST_RED;
            PH_GREEN:  return ST_GREEN;
            PH_YELLOW: return ST_YELLOW;
            default:   return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_decode.sv
// rtl/tlc_phase_decode.sv - combinational one-hot lights to phase decode
module tlc_phase_decode
    import tlc_pkg::*;
(
    input  logic [2:0] lights,
    output logic       valid,
    output phase_t     phase
);

    always_comb begin
        valid = 1'b1;
        phase = PH_NONE;
        case (lights)
            LT_RED:    phase = PH_RED;
            LT_GREEN:  phase = PH_GREEN;
            LT_YELLOW: phase = PH_YELLOW;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lights bus order/dwell checker with sticky fault and cycle counter
module traffic_light_monitor
    import tlc_pkg::*;
#(
    parameter int RED_CYCLES    = 6,
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 3,
    parameter int DWELL_W       = 8,
    parameter int CYC_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights,
    input  logic             clear_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             cycle_done,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    logic               dec_valid;
    phase_t             dec_phase;
    state_t             state, state_n;
    phase_t             prev, prev_n;
    logic [DWELL_W-1:0] dwell, dwell_n, dwell_exp;
    fault_t             flt;
    logic               done_n;

    tlc_phase_decode u_decode (
        .lights (lights),
        .valid  (dec_valid),
        .phase  (dec_phase)
    );

    always_comb begin
        case (state)
            ST_RED:    dwell_exp = DWELL_W'(RED_CYCLES);
            ST_GREEN:  dwell_exp = DWELL_W'(GREEN_CYCLES);
            ST_YELLOW: dwell_exp = DWELL_W'(YELLOW_CYCLES);
            default:   dwell_exp = '0;
        endcase
    end

    // Encoding is checked first so it dominates every tracking-state fault.
    always_comb begin
        flt     = FLT_NONE;
        state_n = state;
        prev_n  = prev;
        dwell_n = dwell;
        done_n  = 1'b0;
        if (!dec_valid) begin
            flt     = FLT_ENC;
            state_n = ST_SYNC;
            prev_n  = PH_NONE;
            dwell_n = '0;
        end else if (state == ST_SYNC) begin
            prev_n = dec_phase;
            if (prev == PH_RED && dec_phase == PH_GREEN) begin
                state_n = ST_GREEN;
                dwell_n = DWELL_ONE;
            end
        end else begin
            prev_n = dec_phase;
            if (dec_phase == state_phase(state)) begin
                if (dwell >= dwell_exp) begin
                    flt     = FLT_LONG;
                    state_n = ST_SYNC;
                    dwell_n = '0;
                end else if (dwell != '1) begin
                    dwell_n = dwell + DWELL_ONE;
                end
            end else if (dec_phase == next_phase(state_phase(state))) begin
                if (dwell < dwell_exp) begin
                    flt     = FLT_SHORT;
                    state_n = ST_SYNC;
                    dwell_n = '0;
                end else begin
                    state_n = phase_state(dec_phase);
                    dwell_n = DWELL_ONE;
                    done_n  = (state == ST_YELLOW);
                end
            end else begin
                flt     = FLT_TRANS;
                state_n = ST_SYNC;
                dwell_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_SYNC;
            prev        <= PH_NONE;
            dwell       <= '0;
            phase       <= 2'd0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            dwell      <= dwell_n;
            phase      <= dec_phase;
            locked     <= (state_n != ST_SYNC);
            cycle_done <= done_n;
            if (done_n) begin
                cycle_count <= cycle_count + 1'b1;
            end
            // A fresh fault beats a simultaneous clear, and the first fault's code is kept.
            if (flt != FLT_NONE) begin
                fault <= 1'b1;
                if (!fault || clear_err) begin
                    fault_code <= flt;
                end
            end else if (clear_err) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed bench with run-length reference model for traffic_light_monitor
module tb_traffic_light_monitor;
    import tlc_pkg::*;

    localparam int RC = 6;
    localparam int GC = 5;
    localparam int YC = 3;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  lights = 3'b000;
    logic        clear_err = 1'b0;
    logic [1:0]  phase;
    logic        locked;
    logic        fault;
    logic [2:0]  fault_code;
    logic        cycle_done;
    logic [15:0] cycle_count;
    logic        dec_valid;
    phase_t      dec_phase;

    int checks = 0;
    int errors = 0;
    int ndone = 0;

    // Reference model: tracks runs of identical samples rather than FSM states.
    int m_run_ph, m_len, m_phase, m_code, m_count;
    bit m_synced, m_fault, m_done;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .RED_CYCLES    (RC),
        .GREEN_CYCLES  (GC),
        .YELLOW_CYCLES (YC),
        .DWELL_W       (8),
        .CYC_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lights      (lights),
        .clear_err   (clear_err),
        .phase       (phase),
        .locked      (locked),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count)
    );

    tlc_phase_decode u_dec (
        .lights (lights),
        .valid  (dec_valid),
        .phase  (dec_phase)
    );

    function automatic int bph(input logic [2:0] l);
        case (l)
            3'b100:  return 1;
            3'b001:  return 2;
            3'b010:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int bexp(input int p);
        return (p == 1) ? RC : (p == 2) ? GC : YC;
    endfunction

    function automatic int bnext(input int p);
        return (p == 3) ? 1 : p + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run_ph = 0; m_len = 0; m_phase = 0; m_code = 0; m_count = 0;
        m_synced = 0; m_fault = 0; m_done = 0;
    endtask

    task automatic model_step(input logic [2:0] l, input logic clr);
        int p;
        int code;
        p = bph(l);
        code = 0;
        m_done = 0;
        if (p == 0) begin
            code = 1;
            m_synced = 0;
            m_run_ph = 0;
            m_len = 0;
        end else if (p == m_run_ph) begin
            m_len++;
            if (m_synced && m_len > bexp(p)) begin
                code = 4;
                m_synced = 0;
            end
        end else begin
            if (m_synced) begin
                if (p != bnext(m_run_ph)) code = 2;
                else if (m_len < bexp(m_run_ph)) code = 3;
                else if (m_run_ph == 3) begin
                    m_done = 1;
                    m_count = (m_count + 1) % 65536;
                end
                if (code != 0) m_synced = 0;
            end else begin
                m_synced = (m_run_ph == 1 && p == 2);
            end
            m_run_ph = p;
            m_len = 1;
        end
        m_phase = p;
        if (code != 0) begin
            if (!m_fault || clr) m_code = code;
            m_fault = 1;
        end else if (clr) begin
            m_fault = 0;
            m_code = 0;
        end
    endtask

    task automatic check_outputs();
        chk("phase", phase, m_phase);
        chk("locked", locked, m_synced);
        chk("fault", fault, m_fault);
        chk("fault_code", fault_code, m_code);
        chk("cycle_done", cycle_done, m_done);
        chk("cycle_count", cycle_count, m_count);
        if (cycle_done === 1'b1) ndone++;
    endtask

    task automatic step(input logic [2:0] l, input logic clr);
        lights = l;
        clear_err = clr;
        #1;
        chk("decode_valid", dec_valid, bph(l) != 0);
        chk("decode_phase", int'(dec_phase), bph(l));
        @(posedge clk);
        model_step(l, clr);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_code"}, fault_code, 0);
        chk({tag, "_done"}, cycle_done, 0);
        chk({tag, "_count"}, cycle_count, 0);
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Free-running RED then three clean cycles
        run(R, 8);
        for (int c = 0; c < 3; c++) begin
            step(G, 1'b0);
            if (c == 0) chk("lock_first_green", locked, 1);
            run(G, GC - 1);
            run(Y, YC);
            run(R, RC);
        end
        chk("done_pulses", ndone, 3);
        chk("count_after_3", cycle_count, 3);
        chk("no_fault_clean", fault, 0);

        // GREEN too short
        run(G, 4);
        step(Y, 1'b0);
        chk("short_fault", fault, 1);
        chk("short_code", fault_code, 3);
        chk("short_unlock", locked, 0);

        // Illegal RED->YELLOW, relock keeps sticky fault
        step(Y, 1'b1);
        chk("clear1", fault, 0);
        run(R, RC);
        run(G, GC);
        run(Y, YC);
        run(R, 2);
        step(Y, 1'b0);
        chk("trans_code", fault_code, 2);
        chk("trans_unlock", locked, 0);
        run(R, 3);
        step(G, 1'b0);
        chk("relock", locked, 1);
        chk("sticky", fault, 1);
        step(G, 1'b1);
        chk("clear2", fault, 0);

        // Bad encodings in GREEN
        step(3'b110, 1'b0);
        chk("enc_code", fault_code, 1);
        chk("enc_phase", phase, 0);
        step(3'b000, 1'b0);
        chk("enc_keep_code", fault_code, 1);
        step(R, 1'b1);
        chk("clear3", fault, 0);

        // YELLOW too long, then clear racing a new fault
        run(R, RC - 1);
        run(G, GC);
        run(Y, YC);
        step(Y, 1'b0);
        chk("long_code", fault_code, 4);
        chk("long_fault", fault, 1);
        step(3'b111, 1'b1);
        chk("clr_vs_new_fault", fault, 1);
        chk("clr_vs_new_code", fault_code, 1);
        step(R, 1'b1);
        chk("clear4", fault_code, 0);

        // Asynchronous reset mid-GREEN
        step(G, 1'b0);
        step(G, 1'b0);
        chk("pre_reset_locked", locked, 1);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run(G, 2);
        chk("no_lock_without_red", locked, 0);
        run(R, 2);
        step(G, 1'b0);
        chk("relock_after_reset", locked, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
